// File: rtl/md5_pad.sv
// md5_pad: packs a big-endian byte stream into 512-bit MD5 blocks, appends the
// 0x80 marker and the 64-bit bit length, and streams each block as four beats.
module md5_pad #(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [31:0]  in_data_i,
  input  logic         in_last_i,
  input  logic [2:0]   in_bytes_i,
  output logic         newtext_o,
  output logic         load_o,
  output logic [127:0] data_o,
  input  logic         core_ready_i,
  output logic         busy_o,
  output logic         done_o
);
  typedef enum logic [2:0] {IDLE, FILL, SEND, WAIT, PAD, DONE} state_t;
  typedef enum logic [1:0] {PEND_MORE, PEND_PAD, PEND_FINAL} pend_t;

  state_t             state_reg, state_next;
  pend_t              pend_reg;
  logic [15:0][31:0]  blk_reg;
  logic [3:0]         idx_reg;
  logic [LEN_W-1:0]   len_reg;
  logic               marked_reg;
  logic [1:0]         beat_reg;

  logic               accept;
  logic [2:0]         k;
  logic [31:0]        swapped;
  logic [31:0]        word_in;
  logic [4:0]         mark_pos;
  logic [LEN_W-1:0]   len_sum;
  logic [63:0]        len_sum64;
  logic [63:0]        len_reg64;

  assign accept    = (state_reg == FILL) && in_valid_i;
  assign k         = (!in_last_i || (in_bytes_i > 3'd4)) ? 3'd4 : in_bytes_i;
  assign swapped   = {in_data_i[7:0], in_data_i[15:8], in_data_i[23:16], in_data_i[31:24]};
  assign mark_pos  = (k == 3'd4) ? ({1'b0, idx_reg} + 5'd1) : {1'b0, idx_reg};
  assign len_sum   = len_reg + LEN_W'({k, 3'b000});
  assign len_sum64 = 64'(len_sum);
  assign len_reg64 = 64'(len_reg);

  // Byte gi keeps stream data below k, becomes the 0x80 marker at k, else zero.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign word_in[8*gi +: 8] = (3'(gi) < k)  ? swapped[8*gi +: 8] :
                                  (3'(gi) == k) ? 8'h80 : 8'h00;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start_i) state_next = FILL;
      FILL: if (accept && (in_last_i || idx_reg == 4'd15)) state_next = SEND;
      SEND: if (beat_reg == 2'd3) state_next = WAIT;
      WAIT: begin
        if (core_ready_i) begin
          case (pend_reg)
            PEND_MORE: state_next = FILL;
            PEND_PAD:  state_next = PAD;
            default:   state_next = DONE;
          endcase
        end
      end
      PAD:     state_next = SEND;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign in_ready_o = (state_reg == FILL);
  assign busy_o     = (state_reg != IDLE);
  assign done_o     = (state_reg == DONE);
  assign load_o     = (state_reg == SEND);
  assign newtext_o  = reset && (state_reg == IDLE) && start_i;
  assign data_o     = load_o ? {blk_reg[{beat_reg, 2'd0}], blk_reg[{beat_reg, 2'd1}],
                                blk_reg[{beat_reg, 2'd2}], blk_reg[{beat_reg, 2'd3}]} : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blk_reg    <= '0;
      idx_reg    <= '0;
      len_reg    <= '0;
      pend_reg   <= PEND_MORE;
      marked_reg <= 1'b0;
      beat_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            blk_reg    <= '0;
            idx_reg    <= '0;
            len_reg    <= '0;
            pend_reg   <= PEND_MORE;
            marked_reg <= 1'b0;
            beat_reg   <= '0;
          end
        end
        FILL: begin
          if (accept) begin
            blk_reg[idx_reg] <= word_in;
            len_reg          <= len_sum;
            idx_reg          <= idx_reg + 4'd1;
            beat_reg         <= '0;
            if (in_last_i) begin
              if (k == 3'd4 && idx_reg != 4'd15) blk_reg[idx_reg + 4'd1] <= 32'h0000_0080;
              // Length fits only if the marker left words 14 and 15 free.
              if (mark_pos <= 5'd13) begin
                blk_reg[14] <= len_sum64[31:0];
                blk_reg[15] <= len_sum64[63:32];
                pend_reg    <= PEND_FINAL;
              end else begin
                pend_reg   <= PEND_PAD;
                marked_reg <= (mark_pos != 5'd16);
              end
            end else begin
              pend_reg <= PEND_MORE;
            end
          end
        end
        SEND: beat_reg <= beat_reg + 2'd1;
        WAIT: begin
          if (core_ready_i && pend_reg == PEND_MORE) begin
            blk_reg <= '0;
            idx_reg <= '0;
          end
        end
        PAD: begin
          blk_reg     <= '0;
          blk_reg[0]  <= marked_reg ? 32'h0 : 32'h0000_0080;
          blk_reg[14] <= len_reg64[31:0];
          blk_reg[15] <= len_reg64[63:32];
          pend_reg    <= PEND_FINAL;
          beat_reg    <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_md5_pad.sv
// tb_md5_pad: drives byte messages into md5_pad and compares every emitted beat
// against MD5 padding computed directly from the message bytes.
module tb_md5_pad;
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start_i = 1'b0;
  logic         in_valid_i = 1'b0;
  logic         in_last_i = 1'b0;
  logic         core_ready_i = 1'b0;
  logic [31:0]  in_data_i = '0;
  logic [2:0]   in_bytes_i = '0;
  logic         in_ready_o, newtext_o, load_o, busy_o, done_o;
  logic [127:0] data_o;

  int checks = 0;
  int errors = 0;
  logic [7:0]   msg_q[$];
  logic [127:0] exp_q[$];
  logic [127:0] beats[$];
  int nt_cnt, done_cnt, overlap_err, zero_err, gap_err, cyc, last_core_cyc;
  int core_delay = 10;
  int beat_mod = 0;

  always #5 clk = ~clk;

  md5_pad dut (
    .clk(clk), .reset(reset), .start_i(start_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .in_data_i(in_data_i), .in_last_i(in_last_i),
    .in_bytes_i(in_bytes_i), .newtext_o(newtext_o), .load_o(load_o),
    .data_o(data_o), .core_ready_i(core_ready_i), .busy_o(busy_o), .done_o(done_o)
  );

  // Output monitor, sampling on the falling edge.
  initial begin
    last_core_cyc = -100;
    forever begin
      @(negedge clk);
      cyc++;
      if (load_o) beats.push_back(data_o);
      if (!load_o && data_o != '0) zero_err++;
      if (newtext_o) nt_cnt++;
      if (load_o && (newtext_o || in_ready_o)) overlap_err++;
      if (done_o) begin
        done_cnt++;
        if (cyc - last_core_cyc != 1) gap_err++;
      end
      if (core_ready_i) last_core_cyc = cyc;
    end
  end

  // Hash-core model: answers each 4-beat block after core_delay cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) beat_mod = 0;
      else if (load_o) begin
        beat_mod++;
        if (beat_mod == 4) begin
          beat_mod = 0;
          repeat (core_delay) @(posedge clk);
          #1 core_ready_i = 1'b1;
          @(posedge clk);
          #1 core_ready_i = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    check(tag, 128'(obs), 128'(exp));
  endtask

  function automatic logic [127:0] get_beat(input int i);
    if (i < beats.size()) return beats[i];
    return 'x;
  endfunction

  task automatic clear_mon();
    beats.delete();
    nt_cnt = 0; done_cnt = 0; overlap_err = 0; zero_err = 0; gap_err = 0;
  endtask

  task automatic set_random_msg(input int len);
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
  endtask

  // Reference: append 0x80, zero-fill to 56 mod 64, append 64-bit LE bit length.
  task automatic build_expected();
    logic [7:0]   p[$];
    logic [63:0]  bits;
    logic [127:0] v;
    p = msg_q;
    exp_q.delete();
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    bits = 64'(msg_q.size()) * 64'd8;
    for (int i = 0; i < 8; i++) p.push_back(8'(bits >> (8 * i)));
    for (int b = 0; b < p.size() / 16; b++) begin
      for (int w = 0; w < 4; w++)
        v[127 - 32*w -: 32] = {p[16*b + 4*w + 3], p[16*b + 4*w + 2], p[16*b + 4*w + 1], p[16*b + 4*w]};
      exp_q.push_back(v);
    end
  endtask

  function automatic logic [31:0] make_word(input int wi);
    logic [31:0] w;
    for (int j = 0; j < 4; j++)
      w[31 - 8*j -: 8] = (4*wi + j < msg_q.size()) ? msg_q[4*wi + j] : 8'($urandom);
    return w;
  endfunction

  task automatic feed(input bit k0_extra, input bit start_valid, input bit stray);
    int n, nw, cnt, t;
    bit acc;
    n  = msg_q.size();
    nw = (n == 0) ? 1 : (n + 3) / 4 + (((n % 4) == 0 && k0_extra) ? 1 : 0);
    @(posedge clk); #1;
    start_i = 1'b1;
    if (start_valid) begin
      in_valid_i = 1'b1;
      in_data_i  = make_word(0);
      in_last_i  = 1'b0;
      in_bytes_i = 3'd4;
    end
    @(negedge clk);
    check_int("newtext_on_start", int'(newtext_o), 1);
    check_int("no_ready_on_start", int'(in_ready_o), 0);
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int wi = 0; wi < nw; wi++) begin
      cnt = n - 4 * wi;
      if (cnt > 4) cnt = 4;
      if (cnt < 0) cnt = 0;
      if (!(start_valid && wi == 0) && $urandom_range(0, 3) == 0) begin
        in_valid_i = 1'b0;
        repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
      end
      if (stray && wi == 1) begin
        in_valid_i   = 1'b0;
        core_ready_i = 1'b1;
        @(posedge clk); #1;
        core_ready_i = 1'b0;
      end
      in_valid_i = 1'b1;
      in_data_i  = make_word(wi);
      in_last_i  = (wi == nw - 1);
      in_bytes_i = in_last_i ? 3'(cnt) : 3'($urandom);
      t = 0;
      do begin
        @(negedge clk);
        acc = in_ready_o;
        @(posedge clk); #1;
        t++;
      end while (!acc && t < 200);
      check_int($sformatf("word%0d_accepted", wi), int'(acc), 1);
    end
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (done_cnt == 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check_int("done_seen", (done_cnt != 0) ? 1 : 0, 1);
    repeat (3) @(negedge clk);
    check_int("idle_after_done", int'(busy_o), 0);
  endtask

  task automatic check_msg(input string tag);
    build_expected();
    $display("msg %s: %0d bytes, %0d beats expected, %0d beats seen", tag, msg_q.size(), exp_q.size(), beats.size());
    check_int({tag, "_beat_count"}, beats.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), get_beat(i), exp_q[i]);
    check_int({tag, "_newtext_pulses"}, nt_cnt, 1);
    check_int({tag, "_done_pulses"}, done_cnt, 1);
    check_int({tag, "_load_overlap"}, overlap_err, 0);
    check_int({tag, "_data_idle_zero"}, zero_err, 0);
    check_int({tag, "_done_latency"}, gap_err, 0);
  endtask

  task automatic run_msg(input string tag, input bit k0_extra, input bit start_valid, input bit stray);
    clear_mon();
    feed(k0_extra, start_valid, stray);
    wait_done();
    check_msg(tag);
  endtask

  initial begin
    logic [127:0] b;
    int seen, t, bytes0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_flags", 128'({in_ready_o, newtext_o, load_o, busy_o, done_o}), 128'(0));
    check("reset_data", data_o, 128'(0));
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_flags", 128'({in_ready_o, newtext_o, load_o, busy_o, done_o}), 128'(0));

    // "abc"
    msg_q = '{8'h61, 8'h62, 8'h63};
    core_delay = 10;
    run_msg("abc", 1'b0, 1'b0, 1'b0);
    check("abc_beat0_const", get_beat(0), {32'h80636261, 96'h0});
    check("abc_beat3_const", get_beat(3), {64'h0, 32'h00000018, 32'h0});

    // Empty message
    msg_q.delete();
    run_msg("empty", 1'b0, 1'b0, 1'b0);
    check("empty_beat0_const", get_beat(0), {32'h00000080, 96'h0});
    check("empty_beat3_const", get_beat(3), 128'h0);

    // 56 bytes: marker lands in word 14, length spills to a second block
    set_random_msg(56);
    run_msg("len56", 1'b0, 1'b0, 1'b0);
    b = get_beat(3);
    check("len56_blk1_w14", 128'(b[63:32]), 128'h80);
    check("len56_blk1_w15", 128'(b[31:0]), 128'h0);
    check("len56_blk2_beat3", get_beat(7), {64'h0, 32'h000001C0, 32'h0});

    // 64 bytes: marker starts the second block
    set_random_msg(64);
    run_msg("len64", 1'b0, 1'b0, 1'b0);
    check("len64_blk2_beat0", get_beat(4), {32'h00000080, 96'h0});
    check("len64_blk2_beat3", get_beat(7), {64'h0, 32'h00000200, 32'h0});

    // start_i with in_valid_i in IDLE, stray core_ready_i during FILL
    set_random_msg(11);
    run_msg("stray", 1'b0, 1'b1, 1'b1);

    // Reset during the second SEND beat
    set_random_msg(20);
    clear_mon();
    feed(1'b0, 1'b0, 1'b0);
    seen = 0;
    t = 0;
    while (seen < 2 && t < 200) begin
      @(negedge clk);
      if (load_o) seen++;
      t++;
    end
    check_int("reset_reached_beat2", seen, 2);
    bytes0 = beats.size();
    #1 reset = 1'b0;
    start_i = 1'b1;
    #1;
    check("midreset_flags", 128'({in_ready_o, newtext_o, load_o, busy_o, done_o}), 128'(0));
    check("midreset_data", data_o, 128'(0));
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    start_i = 1'b0;
    repeat (30) @(negedge clk);
    check_int("no_load_after_reset", beats.size(), bytes0);
    check_int("no_done_after_reset", done_cnt, 0);
    set_random_msg(9);
    run_msg("after_reset", 1'b0, 1'b0, 1'b0);

    // Random messages
    for (int r = 0; r < 8; r++) begin
      core_delay = $urandom_range(1, 20);
      set_random_msg($urandom_range(0, 140));
      run_msg($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/md5_pad.md
MD5_PAD -- requirements
Module: md5_pad

Interface
REQ-001 Parameter LEN_W, default 64: width of the message bit-length counter; lengths wrap modulo 2^LEN_W.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; clears all state immediately when low.
REQ-004 start_i  in  1  begin a new message; sampled only in IDLE.
REQ-005 in_valid_i  in  1  upstream word valid.
REQ-006 in_ready_o  out  1  word accepted when in_valid_i and in_ready_o are both high.
REQ-007 in_data_i  in  32  message bytes; [31:24] is the first byte in stream order.
REQ-008 in_last_i  in  1  current word is the final word of the message.
REQ-009 in_bytes_i  in  3  valid bytes in a last word, 0..4, taken from the MSB end; 4 is implied when in_last_i is low.
REQ-010 newtext_o  out  1  one-cycle pulse to the hash core that reinitialises its chaining values.
REQ-011 load_o  out  1  beat strobe to the hash core.
REQ-012 data_o  out  128  padded block beat in little-endian word form.
REQ-013 core_ready_i  in  1  one-cycle hash-core pulse marking the end of a block hash.
REQ-014 busy_o  out  1  high in every state except IDLE.
REQ-015 done_o  out  1  one-cycle pulse after the core completes the final block.

Function
REQ-016 Byte order: each stream word {b0,b1,b2,b3} is stored as MD5 word {b3,b2,b1,b0}, with b0 as the LSB.
REQ-017 The block buffer holds 16 x 32-bit words with a 4-bit write index.
REQ-018 The FSM states are IDLE, FILL, SEND, WAIT, PAD and DONE.
REQ-019 IDLE transition: on start_i, pulse newtext_o, clear the buffer, index and bit counter, and enter FILL on the next cycle; in_ready_o is 0 in the start cycle.
REQ-020 In FILL, in_ready_o is 1 and other states hold it at 0; each accepted word is written at the index, the index increments, and the bit counter adds 32.
REQ-021 Non-last word that fills index 15: enter SEND; the pending flag is "more data".
REQ-022 Last word with k = in_bytes_i: add 8k to the bit counter and place 0x80 in byte k of the same word if k<4, or in byte 0 of the next word if k=4.
REQ-023 After a last word, every byte following 0x80 up to word 15 is zero.
REQ-024 If the 0x80 byte lands in word 13 or lower, words 14 and 15 take the bit count (low 32 bits, then high 32 bits), SEND begins, and the pending flag is "final".
REQ-025 Otherwise (0x80 in word 14 or 15, or word 15 full with k=4) SEND begins with the pending flag "pad".
REQ-026 A last word with k=0 places 0x80 at byte 0 of the current index.
REQ-027 SEND drives load_o high for exactly 4 consecutive cycles with data_o = {w0,w1,w2,w3}, {w4..w7}, {w8..w11}, {w12..w15}, where w0 sits in [127:96]; the FSM then enters WAIT.
REQ-028 data_o is 0 whenever load_o is low.
REQ-029 WAIT holds until core_ready_i, then branches on the pending flag: "more data" clears the buffer and index and returns to FILL; "pad" enters PAD; "final" enters DONE.
REQ-030 PAD builds a block of zeros, plus 0x80 at word 0 byte 0 if not yet emitted, plus the length in words 14 and 15; it then enters SEND with the pending flag "final" on the next cycle.
REQ-031 DONE pulses done_o for one cycle and then returns to IDLE.
REQ-032 start_i outside IDLE is ignored, and in_valid_i outside FILL is never accepted.
REQ-033 A core_ready_i pulse outside WAIT is ignored.
REQ-034 newtext_o is never asserted in the same cycle as load_o.
REQ-035 The first load_o of a message occurs at least 1 cycle after newtext_o.

Reset
REQ-036 While reset is low, the following clear asynchronously: state to IDLE; in_ready_o, newtext_o, load_o, busy_o and done_o to 0; data_o, the buffer, the index, the bit counter and the pending flag to 0.
REQ-037 A reset asserted mid-message abandons that message; after release no load_o occurs until a new start_i.

Verification
REQ-038 Stimulus: start_i, then in_data_i=0x61626300, in_bytes_i=3, in_last_i=1, with core_ready_i 10 cycles after the 4th beat -> required response: newtext_o 1 pulse; beat0 = {0x80636261,0,0,0}; beats 1-2 = 0; beat3 = {0,0,0x00000018,0}; done_o 1 cycle after core_ready_i.
REQ-039 Stimulus: start_i, then in_bytes_i=0, in_last_i=1 (empty message) -> required response: beat0 = {0x00000080,0,0,0}; beat3 = 0; exactly 1 block sent.
REQ-040 Stimulus: 56-byte message (14 words, last with k=4) -> required response: block 1 has word 14 = 0x00000080 and word 15 = 0; block 2 has word 14 = 0x000001C0 and all other words 0; one newtext_o; 8 load_o total.
REQ-041 Stimulus: 64-byte message (16 words, last with k=4) -> required response: block 2 = {0x00000080, 0 ... , w14 = 0x00000200, w15 = 0}; in_ready_o low throughout SEND and WAIT.
REQ-042 Stimulus: reset pulled low during the 2nd SEND beat, then released -> required response: load_o drops immediately; all outputs 0; start_i is accepted normally afterwards.
REQ-043 Stimulus: start_i together with in_valid_i in IDLE, plus core_ready_i pulsed during FILL -> required response: the word is not accepted in the start cycle and the stray core_ready_i changes no state.
